// File: rtl/axi_exer_pkg.sv
// Shared definitions for the AXI memory exerciser: response/burst codes,
// sideband constants, the control FSM encoding and the data pattern.
package axi_exer_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [3:0] AXI_CACHE_DEF = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEF  = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } exer_state_e;

    // One 32-bit lane of the test pattern for a given byte address.
    function automatic logic [31:0] pattern_word(input logic [31:0] addr,
                                                 input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/axi_exer_beat_gen.sv
// Burst/beat address tracking and pattern data for the AXI exerciser.
// The same generator serves the write phase and the read-back phase.
module axi_exer_beat_gen
    import axi_exer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned NUM_BURSTS = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter logic [31:0] SEED       = 32'h1234_5678
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  burst_clr,
    input  logic                  burst_adv,
    input  logic                  beat_clr,
    input  logic                  beat_adv,
    output logic [ID_WIDTH-1:0]   burst_id,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    output logic [8:0]            beat_cnt,
    output logic [DATA_WIDTH-1:0] beat_data,
    output logic                  last_beat,
    output logic                  last_burst
);

    localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES  = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));

    logic [15:0]           burst_idx;
    logic [ADDR_WIDTH-1:0] beat_addr;

    // Burst index and running burst base address (wraps modulo 2^ADDR_WIDTH).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_idx  <= '0;
            burst_addr <= BASE;
        end else if (burst_clr) begin
            burst_idx  <= '0;
            burst_addr <= BASE;
        end else if (burst_adv) begin
            burst_idx  <= burst_idx + 16'd1;
            burst_addr <= burst_addr + BURST_BYTES;
        end
    end

    // Beat counter and running beat address within the current burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            beat_addr <= '0;
        end else if (beat_clr) begin
            beat_cnt  <= '0;
            beat_addr <= burst_addr;
        end else if (beat_adv) begin
            beat_cnt  <= beat_cnt + 9'd1;
            beat_addr <= beat_addr + BEAT_BYTES;
        end
    end

    // Derived per-beat data and burst/beat boundary flags.
    always_comb begin
        burst_id   = ID_WIDTH'(burst_idx);
        beat_data  = {(DATA_WIDTH / 32){pattern_word(32'(beat_addr), SEED)}};
        last_beat  = (beat_cnt == 9'(BURST_LEN - 1));
        last_burst = (burst_idx == 16'(NUM_BURSTS - 1));
    end

endmodule

// File: rtl/axi_mem_exerciser.sv
// AXI4 master that writes NUM_BURSTS INCR bursts of a deterministic pattern,
// reads the region back and counts mismatches and response errors.
// Optional build macro AXI_EXER_THROTTLE_EN inserts LFSR-driven W gaps and
// B/R ready back-pressure.
module axi_mem_exerciser
    import axi_exer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned NUM_BURSTS = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter logic [31:0] SEED       = 32'h1234_5678
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,

    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [7:0] AXI_LEN  = 8'(BURST_LEN - 1);

    exer_state_e state, state_nxt;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, r_end;
    logic                  start_acc;
    logic                  burst_clr, burst_adv, beat_clr, beat_adv;
    logic                  throttle_ok, ready_gate;
    logic [ID_WIDTH-1:0]   burst_id;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [8:0]            beat_cnt;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  last_beat, last_burst;
    logic [8:0]            err_inc;
    logic [16:0]           err_sum;

`ifdef AXI_EXER_THROTTLE_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR (taps 8,6,5,4) gating W beats and B/R ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Throttle taps.
    always_comb begin
        throttle_ok = lfsr[0];
        ready_gate  = lfsr[1];
    end
`else
    // No throttling: beats back-to-back, ready held high.
    always_comb begin
        throttle_ok = 1'b1;
        ready_gate  = 1'b1;
    end
`endif

    axi_exer_beat_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .NUM_BURSTS (NUM_BURSTS),
        .BASE_ADDR  (BASE_ADDR),
        .SEED       (SEED)
    ) u_beat_gen (
        .clk        (clk),
        .rst        (rst),
        .burst_clr  (burst_clr),
        .burst_adv  (burst_adv),
        .beat_clr   (beat_clr),
        .beat_adv   (beat_adv),
        .burst_id   (burst_id),
        .burst_addr (burst_addr),
        .beat_cnt   (beat_cnt),
        .beat_data  (beat_data),
        .last_beat  (last_beat),
        .last_burst (last_burst)
    );

    // Handshake decode and sequencing strobes for the beat generator.
    always_comb begin
        aw_hs     = m_axi_awvalid && m_axi_awready;
        w_hs      = m_axi_wvalid && m_axi_wready;
        b_hs      = m_axi_bvalid && m_axi_bready;
        ar_hs     = m_axi_arvalid && m_axi_arready;
        r_hs      = m_axi_rvalid && m_axi_rready;
        // An early rlast closes the burst just like the expected final beat.
        r_end     = r_hs && (m_axi_rlast || last_beat);
        start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
        burst_clr = start_acc || (b_hs && last_burst);
        burst_adv = (b_hs && !last_burst) || (r_end && !last_burst);
        beat_clr  = aw_hs || ar_hs;
        beat_adv  = w_hs || r_hs;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_AW;
            ST_AW:            if (aw_hs) state_nxt = ST_W;
            ST_W:             if (w_hs && last_beat) state_nxt = ST_B;
            ST_B:             if (b_hs) state_nxt = last_burst ? ST_AR : ST_AW;
            ST_AR:            if (ar_hs) state_nxt = ST_R;
            ST_R:             if (r_end) state_nxt = last_burst ? ST_DONE : ST_AR;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Valid registers: rise one cycle after state entry, held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axi_awvalid <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
        end else begin
            m_axi_awvalid <= (state == ST_AW) && !aw_hs;
            m_axi_arvalid <= (state == ST_AR) && !ar_hs;
            if (state != ST_W)
                m_axi_wvalid <= 1'b0;
            else if (w_hs)
                m_axi_wvalid <= !last_beat && throttle_ok;
            else if (!m_axi_wvalid)
                m_axi_wvalid <= throttle_ok;
        end
    end

    // Error increment for the current cycle's B or R handshake.
    always_comb begin
        err_inc = '0;
        if (b_hs && ((m_axi_bresp != RESP_OKAY) || (m_axi_bid != burst_id)))
            err_inc = 9'd1;
        if (r_hs) begin
            // Early rlast: this beat plus every beat still expected is an error.
            if (m_axi_rlast && !last_beat)
                err_inc = 9'(BURST_LEN) - beat_cnt;
            else if ((m_axi_rdata != beat_data) || (m_axi_rresp != RESP_OKAY) ||
                     (m_axi_rid != burst_id) || (m_axi_rlast != last_beat))
                err_inc = 9'd1;
        end
        err_sum = {1'b0, err_count} + {8'd0, err_inc};
    end

    // Saturating error counter, cleared by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             err_count <= '0;
        else if (start_acc)  err_count <= '0;
        else if (err_sum[16]) err_count <= '1;
        else                 err_count <= err_sum[15:0];
    end

    // Status, ready and payload outputs; payload is zero whenever valid is low.
    always_comb begin
        busy          = (state == ST_AW) || (state == ST_W) || (state == ST_B) ||
                        (state == ST_AR) || (state == ST_R);
        done          = (state == ST_DONE);
        pass          = done && (err_count == '0);
        m_axi_bready  = (state == ST_B) && ready_gate;
        m_axi_rready  = (state == ST_R) && ready_gate;

        m_axi_awid    = m_axi_awvalid ? burst_id      : '0;
        m_axi_awaddr  = m_axi_awvalid ? burst_addr    : '0;
        m_axi_awlen   = m_axi_awvalid ? AXI_LEN       : '0;
        m_axi_awsize  = m_axi_awvalid ? AXI_SIZE      : '0;
        m_axi_awburst = m_axi_awvalid ? BURST_INCR    : '0;
        m_axi_awlock  = 1'b0;
        m_axi_awcache = m_axi_awvalid ? AXI_CACHE_DEF : '0;
        m_axi_awprot  = AXI_PROT_DEF;

        m_axi_arid    = m_axi_arvalid ? burst_id      : '0;
        m_axi_araddr  = m_axi_arvalid ? burst_addr    : '0;
        m_axi_arlen   = m_axi_arvalid ? AXI_LEN       : '0;
        m_axi_arsize  = m_axi_arvalid ? AXI_SIZE      : '0;
        m_axi_arburst = m_axi_arvalid ? BURST_INCR    : '0;
        m_axi_arlock  = 1'b0;
        m_axi_arcache = m_axi_arvalid ? AXI_CACHE_DEF : '0;
        m_axi_arprot  = AXI_PROT_DEF;

        m_axi_wdata   = m_axi_wvalid ? beat_data : '0;
        m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
        m_axi_wlast   = m_axi_wvalid && last_beat;
    end

endmodule

// File: tb/tb_axi_mem_exerciser.sv
// Self-checking bench for axi_mem_exerciser with a small AXI slave memory
// model and a scoreboard of expected AW/AR requests and W data.
module tb_axi_mem_exerciser;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 8;
    localparam int unsigned IW   = 8;
    localparam int unsigned BL   = 4;
    localparam int unsigned NB   = 8;
    localparam int unsigned BASE = 'hF0;
    localparam logic [31:0] SEED = 32'h1234_5678;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [15:0]   err_count;

    logic [IW-1:0] m_axi_awid;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awlock;
    logic [3:0]    m_axi_awcache;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [IW-1:0] m_axi_bid = '0;
    logic [1:0]    m_axi_bresp = '0;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [IW-1:0] m_axi_rid = '0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = '0;
    logic          m_axi_rlast = 1'b0;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;

    always #5 clk = ~clk;

    axi_mem_exerciser #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .BURST_LEN  (BL),
        .NUM_BURSTS (NB),
        .BASE_ADDR  (BASE),
        .SEED       (SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [7:0] a);
        return {24'd0, a} ^ SEED;
    endfunction

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] id;
    } ax_t;

    ax_t         aw_q[$];
    ax_t         ar_q[$];
    logic [31:0] w_q[$];

    logic [31:0] mem [64];
    int          aw_stall = 0;
    bit          stall_on = 0;
    logic [7:0]  held_addr = '0;
    logic [7:0]  wr_addr = '0, wr_id = '0, rd_addr = '0, rd_id = '0;
    int          wr_beat = 0, rd_beat = 0;
    bit          b_pend = 0, r_act = 0;
    logic [7:0]  b_id = '0;
    logic [1:0]  b_resp = '0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int          slverr_burst = -1;
    int          corrupt_beat = -1;

    // Slave model: decides inputs at each negedge for the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = '0;
                m_axi_rvalid = 0; m_axi_rid = '0; m_axi_rdata = '0;
                m_axi_rresp = '0; m_axi_rlast = 0;
                b_pend = 0; r_act = 0; stall_on = 0;
            end else begin
                // B channel
                m_axi_bvalid = b_pend;
                m_axi_bid    = b_pend ? b_id : '0;
                m_axi_bresp  = b_pend ? b_resp : '0;
                if (m_axi_bvalid && m_axi_bready) begin
                    b_pend = 0;
                    n_b++;
                end

                // W channel
                m_axi_wready = 1;
                if (m_axi_wvalid && m_axi_wready) begin
                    logic [7:0]  a;
                    logic [31:0] exp_d;
                    a = wr_addr + 8'(wr_beat * 4);
                    mem[a[7:2]] = m_axi_wdata;
                    exp_d = (w_q.size() > 0) ? w_q.pop_front() : 'x;
                    check_eq("w_data", m_axi_wdata, exp_d);
                    check_eq("w_last", 32'(m_axi_wlast), 32'(wr_beat == int'(BL - 1)));
                    check_eq("w_strb", 32'(m_axi_wstrb), 32'hF);
                    if (wr_beat == int'(BL - 1)) begin
                        b_pend = 1;
                        b_id   = wr_id;
                        b_resp = (n_aw - 1 == slverr_burst) ? 2'b10 : 2'b00;
                    end
                    wr_beat++;
                    n_w++;
                end

                // AW channel, optionally stalled while awvalid is high
                if (aw_stall > 0 && (stall_on || m_axi_awvalid)) begin
                    if (!stall_on) begin
                        stall_on  = 1;
                        held_addr = m_axi_awaddr;
                    end else begin
                        check_eq("aw_hold_valid", 32'(m_axi_awvalid), 32'd1);
                        check_eq("aw_hold_addr", 32'(m_axi_awaddr), 32'(held_addr));
                    end
                    m_axi_awready = 0;
                    aw_stall--;
                    if (aw_stall == 0) stall_on = 0;
                end else begin
                    m_axi_awready = 1;
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    ax_t e;
                    e = (aw_q.size() > 0) ? aw_q.pop_front() : 'x;
                    check_eq("aw_addr", 32'(m_axi_awaddr), 32'(e.addr));
                    check_eq("aw_id", 32'(m_axi_awid), 32'(e.id));
                    check_eq("aw_len", 32'(m_axi_awlen), BL - 1);
                    check_eq("aw_size", 32'(m_axi_awsize), 32'd2);
                    check_eq("aw_burst", 32'(m_axi_awburst), 32'd1);
                    check_eq("aw_cache", 32'(m_axi_awcache), 32'h3);
                    wr_addr = m_axi_awaddr;
                    wr_id   = m_axi_awid;
                    wr_beat = 0;
                    n_aw++;
                end

                // R channel
                m_axi_rvalid = r_act;
                if (r_act) begin
                    logic [7:0] a;
                    a = rd_addr + 8'(rd_beat * 4);
                    m_axi_rdata = mem[a[7:2]] ^ ((n_r == corrupt_beat) ? 32'd1 : 32'd0);
                    m_axi_rid   = rd_id;
                    m_axi_rresp = 2'b00;
                    m_axi_rlast = (rd_beat == int'(BL - 1));
                end else begin
                    m_axi_rdata = '0; m_axi_rid = '0; m_axi_rlast = 0;
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    if (m_axi_rlast) r_act = 0;
                    rd_beat++;
                    n_r++;
                end

                // AR channel
                m_axi_arready = 1;
                if (m_axi_arvalid && m_axi_arready) begin
                    ax_t e;
                    e = (ar_q.size() > 0) ? ar_q.pop_front() : 'x;
                    check_eq("ar_addr", 32'(m_axi_araddr), 32'(e.addr));
                    check_eq("ar_id", 32'(m_axi_arid), 32'(e.id));
                    check_eq("ar_len", 32'(m_axi_arlen), BL - 1);
                    rd_addr = m_axi_araddr;
                    rd_id   = m_axi_arid;
                    rd_beat = 0;
                    r_act   = 1;
                    n_ar++;
                end
            end
        end
    end

    task automatic push_expected();
        for (int b = 0; b < int'(NB); b++) begin
            ax_t e;
            e.addr = 8'(BASE + b * BL * 4);
            e.id   = 8'(b);
            aw_q.push_back(e);
            ar_q.push_back(e);
            for (int k = 0; k < int'(BL); k++)
                w_q.push_back(pat(e.addr + 8'(k * 4)));
        end
    endtask

    task automatic clear_counts();
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic run_once(input string tag, input int unsigned exp_err, input bit poke_start);
        push_expected();
        clear_counts();
        start = 1;
        @(negedge clk);
        start = 0;
        check_eq({tag, "_busy_run"}, 32'(busy), 32'd1);
        if (poke_start) begin
            repeat (20) @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        wait_done(tag);
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_eq({tag, "_err"}, 32'(err_count), exp_err);
        check_eq({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        check_eq({tag, "_n_aw"}, n_aw, NB);
        check_eq({tag, "_n_w"}, n_w, NB * BL);
        check_eq({tag, "_n_b"}, n_b, NB);
        check_eq({tag, "_n_ar"}, n_ar, NB);
        check_eq({tag, "_n_r"}, n_r, NB * BL);
        check_eq({tag, "_q_left"}, aw_q.size() + ar_q.size() + w_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_pass"}, 32'(pass), 0);
        check_eq({tag, "_err"}, 32'(err_count), 0);
        check_eq({tag, "_valids"}, 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 0);
        check_eq({tag, "_readys"}, 32'({m_axi_bready, m_axi_rready}), 0);
        check_eq({tag, "_awaddr"}, 32'(m_axi_awaddr), 0);
        check_eq({tag, "_wdata"}, m_axi_wdata, 0);
        check_eq({tag, "_wlast"}, 32'(m_axi_wlast), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 0;
        @(negedge clk);

        // awready held low for 10 cycles on the first AW; address wraps past 0xFF
        aw_stall = 10;
        run_once("run_stall", 0, 0);
        repeat (5) @(negedge clk);
        check_eq("done_held", 32'(done), 1);
        check_eq("pass_held", 32'(pass), 1);

        // read beat 5 corrupted; a start pulse while busy must be ignored
        corrupt_beat = 5;
        run_once("run_rcorrupt", 1, 1);
        corrupt_beat = -1;

        // SLVERR on burst 2; err_count must restart from zero
        slverr_burst = 2;
        run_once("run_slverr", 1, 0);
        slverr_burst = -1;

        // reset during W beat 2
        push_expected();
        clear_counts();
        start = 1;
        @(negedge clk);
        start = 0;
        begin
            int cyc = 0;
            while (n_w < 2 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check_eq("rst_mid_reach_w2", n_w, 2);
        end
        @(posedge clk);
        #1;
        check_eq("rst_mid_wvalid_pre", 32'(m_axi_wvalid), 1);
        rst = 1;
        #1;
        check_quiet("rst_mid");
        repeat (2) @(negedge clk);
        rst = 0;
        aw_q.delete();
        ar_q.delete();
        w_q.delete();
        @(negedge clk);
        run_once("run_after_rst", 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_mem_exerciser.md
Name: axi_mem_exerciser

Overview:
- Parametrised AXI4 master stimulus/checker for the cosim bench, driving a slave such as axi_ram_impl.
- Runs NUM_BURSTS INCR write bursts of a deterministic data pattern, reads the same region back, compares every beat and reports pass/fail plus an error count.
- Instantiated in the test bench in place of undriven master inputs.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 32.
- ADDR_WIDTH, 8, byte address width.
- ID_WIDTH, 8, AXI ID width.
- BURST_LEN, 4, beats per burst (1..256).
- NUM_BURSTS, 8, bursts per phase (1..65535).
- BASE_ADDR, 0, first byte address; aligned to DATA_WIDTH/8.
- SEED, 32'h1234_5678, pattern XOR seed.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle run request.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  done with err_count==0.
- err_count  out  16  saturating mismatch/response error count.
- m_axi_awid/awaddr/awlen/awsize/awburst  out  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload.
- m_axi_awlock/awcache/awprot  out  1/4/3  constants 0, 4'b0011, 3'b000.
- m_axi_awvalid  out  1 ; m_axi_awready  in  1.
- m_axi_wdata/wstrb/wlast  out  DATA_WIDTH/DATA_WIDTH/8/1  W payload.
- m_axi_wvalid  out  1 ; m_axi_wready  in  1.
- m_axi_bid/bresp  in  ID_WIDTH/2 ; m_axi_bvalid  in  1 ; m_axi_bready  out  1.
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  same widths and values as AW.
- m_axi_arvalid  out  1 ; m_axi_arready  in  1.
- m_axi_rid/rdata/rresp/rlast  in  ID_WIDTH/DATA_WIDTH/2/1 ; m_axi_rvalid  in  1 ; m_axi_rready  out  1.

Behaviour:
- Reset: FSM IDLE; every valid, ready, busy, done, pass and err_count = 0; payload outputs = 0.
- Reset mid-burst abandons the transaction immediately.
- FSM: IDLE -> AW -> W -> B -> (next burst ? AW : AR) -> R -> (next burst ? AR : DONE).
- start is sampled in IDLE or DONE: clears err_count/done/pass, sets busy, burst index i=0. start while busy is ignored.
- Burst address = BASE_ADDR + i*BURST_LEN*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
- awlen = BURST_LEN-1; awsize = log2(DATA_WIDTH/8); awburst = INCR; id = i[ID_WIDTH-1:0].
- Valid rule: a valid is asserted one cycle after state entry and held with payload stable until the handshake; it never drops early.
- W phase: wstrb all ones; beat k data = pattern(addr + k*DATA_WIDTH/8); wlast only on beat BURST_LEN-1.
- B: bready=1 in B. bresp!=OKAY or bid!=id increments err_count by 1.
- R: rready=1 in R. Per beat, compare rdata with pattern, rresp==OKAY, rid==id, and rlast==(beat==BURST_LEN-1). One increment per beat if any check fails.
- If rlast arrives early, remaining expected beats count one error each and the FSM advances.
- pattern(a) = DATA_WIDTH/32 copies of ({zero-ext a to 32} ^ SEED).
- err_count saturates at 16'hFFFF.
- DONE: busy=0, done=1, pass=(err_count==0).
- One outstanding transaction at a time; no AW/W interleave.

Optional Feature:
- Macro AXI_EXER_THROTTLE_EN.
- Defined: an 8-bit LFSR (seed 8'hA5, taps 8,6,5,4) advances every cycle.
- Before asserting wvalid for a new beat, the block waits while LFSR[0]==0.
- rready and bready = LFSR[1] while in R or B.
- Valid-hold rule unchanged.
- Undefined: no gaps; rready/bready constant 1 in their states.

Decomposition:
- Package axi_exer_pkg: resp codes (OKAY, EXOKAY, SLVERR, DECERR), burst codes, FSM state enum, pattern function.
- Sub-module axi_exer_beat_gen: address/beat counter and pattern generator, shared by the W and R paths.

Test Plan:
- Defaults against axi_ram_impl (32/8/8), BURST_LEN 4, NUM_BURSTS 8 -> 8 AW, 32 W, 8 AR, 32 R handshakes; done=1, pass=1, err_count=0.
- Bench flips rdata bit 0 on read beat 5 -> err_count=1, pass=0.
- Slave model returns bresp=SLVERR on burst 2 -> err_count=1.
- BASE_ADDR 8'hF0, NUM_BURSTS 2 -> awaddr 8'hF0 then 8'h00.
- awready held low 10 cycles -> awvalid and awaddr stable for all 10; run still passes.
- rst pulsed during W beat 2 -> all outputs 0 within reset; next start completes with pass=1.
